sram_bus_master: RTL
====================

# sram_bus_master

Hardware initiator for the shared 2K x 8 SRAM bus (11-bit address, 8-bit bidirectional data, WrEn, OutEn) that the `sram` responder serves. It converts a simple valid/ready request port into correctly sequenced SRAM write and read cycles, and returns one response per request. Fabric logic such as pattern testers or DMA-style fillers can then drive the memory without the Nios II PIO software path. It sits between a client FSM and the `address`/`data`/`WrEn`/`OutEn` nets, and is the only driver of those nets when instantiated.

## Interface
Parameters:
- ADDR_W, 11, SRAM address width.
- DATA_W, 8, SRAM data width.
- READ_LAT, 1, number of clock cycles the responder needs from OutEn assertion to valid data; range 1–4.

Ports:
- clk  in  1  system clock (CLOCK_50 domain); all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  client request present.
- req_ready  out  1  master can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse; request complete.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid on reads, 0 on writes.
- address  out  ADDR_W  SRAM address bus.
- data  inout  DATA_W  SRAM data bus; driven only during write cycles, otherwise 'z.
- WrEn  out  1  SRAM write enable, active-low.
- OutEn  out  1  SRAM output enable, active-low.

## Operation
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_WAIT, R_TURN.
- **IDLE**
  - req_ready = 1.
  - When req_valid is high, latch addr, wdata and write into internal registers.
  - Go to W_SETUP if write, else R_SETUP.
- **W_SETUP:** drive address and data; WrEn = 1, OutEn = 1.
- **W_STROBE:** WrEn = 0; address and data remain stable.
- **W_HOLD:**
  - WrEn = 1; data still driven.
  - rsp_valid = 1, rsp_rdata = 0.
  - Go to IDLE.
- **R_SETUP:** drive address; data released; OutEn = 1.
- **R_WAIT:**
  - OutEn = 0 for READ_LAT cycles, counted by a wait counter.
  - On the last R_WAIT cycle, register `data` into rsp_rdata.
- **R_TURN:**
  - OutEn = 1; data stays released (turnaround).
  - rsp_valid = 1 with the captured value.
  - Go to IDLE.
- Bus-contention rules:
  - WrEn and OutEn are never low in the same cycle.
  - data is never driven while OutEn = 0, or in R_SETUP or R_TURN.
- Requests arriving while req_ready = 0 are ignored. The client must hold req_valid and its payload until accepted.
- Back-to-back requests: IDLE lasts exactly one cycle between transactions when req_valid is held high.
- Address is held at the latched value from SETUP through the final state. It keeps its last value in IDLE.

## Timing
- Reset values (also on reset asserted mid-transaction, effective at that clock edge):
  - state = IDLE
  - req_ready = 1
  - rsp_valid = 0
  - rsp_rdata = 0
  - address = 0
  - WrEn = 1, OutEn = 1
  - data = 'z
- An aborted transaction produces no rsp_valid.
- Write latency: accept at edge N, rsp_valid high in cycle N+3. Total 4 cycles per write including IDLE.
- Read latency: accept at edge N, rsp_valid in cycle N+READ_LAT+2. Total READ_LAT+3 cycles per read.
- rsp_valid is exactly one cycle wide. req_ready is 0 from acceptance until the cycle after rsp_valid.
- Address wrap: no auto-increment. The full 0…2^ADDR_W−1 range is passed through unchanged.

## Structure
- Shared package `sram_pkg`, containing:
  - ADDR_W/DATA_W localparams (11/8).
  - State enum `sram_state_t`.
  - Active-low enable constants EN_ON = 1'b0 and EN_OFF = 1'b1.
- One sub-module: `sram_tristate`, an 8-bit bidirectional pad with drive-enable input, output value input and sampled input value output. It keeps `inout` handling out of the FSM.
- The FSM, latch registers and wait counter stay in `sram_bus_master`.

## Test plan
1. Write then read, against a `sram` model with READ_LAT = 1:
   - Stimulus: write addr 0x005 data 0xA5, then read 0x005.
   - Write: rsp_valid 3 cycles after accept.
   - Read: rsp_valid 3 cycles after accept, rsp_rdata = 0xA5.
   - WrEn low for exactly one cycle.
2. Boundaries and back-to-back:
   - Write 0x7FF = 0x3C and 0x000 = 0xC3, back-to-back with req_valid held high.
   - Read both back: 0x3C and 0xC3.
   - Exactly one IDLE cycle between transactions.
3. Bus-protocol checker over 1000 random mixed requests:
   - Never WrEn = 0 and OutEn = 0 together.
   - data driven only in W_* states.
   - Read data matches a scoreboard.
4. Reset mid-operation:
   - Assert reset during W_STROBE of a write of 0xFF to 0x010.
   - Next cycle: WrEn = 1, OutEn = 1, data = 'z, req_ready = 1, no rsp_valid.
5. READ_LAT = 3:
   - Read of a preloaded 0x5A at 0x100.
   - OutEn low for 3 cycles; rsp_valid 5 cycles after accept with 0x5A.
6. Request while busy:
   - Pulse req_valid for one cycle while req_ready = 0.
   - No transaction issued; the only rsp_valid is for the original request.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM bus initiator: bus widths, FSM state
// encoding and the active-low enable levels used on WrEn / OutEn.
package sram_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_SETUP  = 3'd4,
    R_WAIT   = 3'd5,
    R_TURN   = 3'd6
  } sram_state_t;

  // WrEn and OutEn are active-low strobes.
  localparam logic EN_ON  = 1'b0;
  localparam logic EN_OFF = 1'b1;

endpackage

// File: rtl/sram_tristate.sv
// Bidirectional data pad: drives dout_i onto the shared bus while oe_i is
// high, otherwise releases it; din_o always reflects the bus value.
module sram_tristate #(
  parameter int W = 8
) (
  input  logic         oe_i,
  input  logic [W-1:0] dout_i,
  output logic [W-1:0] din_o,
  inout  wire  [W-1:0] pad_io
);

  // Drive or release the pad; sampling path is unconditional.
  assign pad_io = oe_i ? dout_i : {W{1'bz}};
  assign din_o  = pad_io;

endmodule

// File: rtl/sram_bus_master.sv
// SRAM bus initiator. Turns valid/ready client requests into sequenced
// SRAM write (setup/strobe/hold) and read (setup/wait/turnaround) cycles
// and returns one single-cycle response per accepted request.
//
// Request handshake: a request transfers on a rising edge where both
// req_valid and req_ready are high. req_ready is high only in IDLE, so the
// client must hold req_valid and its payload stable until that edge;
// anything presented while req_ready is low is ignored.
module sram_bus_master
  import sram_pkg::*;
#(
  parameter int ADDR_W   = sram_pkg::ADDR_W,
  parameter int DATA_W   = sram_pkg::DATA_W,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data,
  output logic              WrEn,
  output logic              OutEn,
  output logic [2:0]        dbg_state_o,
  output logic              dbg_data_oe_o
);

  // Wait counter runs 0..READ_LAT-1; READ_LAT is limited to 1..4.
  localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

  sram_state_t       state_q;
  logic              ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              drive_q;
  logic              wren_q;
  logic              oen_q;
  logic [1:0]        wait_q;
  logic [DATA_W-1:0] data_in;

  sram_tristate #(.W(DATA_W)) u_pad (
    .oe_i   (drive_q),
    .dout_i (wdata_q),
    .din_o  (data_in),
    .pad_io (data)
  );

  // Transaction FSM; every bus and response output is a register updated
  // on the transition into the state where it must take effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      drive_q     <= 1'b0;
      wren_q      <= EN_OFF;
      oen_q       <= EN_OFF;
      wait_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            ready_q <= 1'b0;
            if (req_write) begin
              drive_q <= 1'b1;
              state_q <= W_SETUP;
            end else begin
              state_q <= R_SETUP;
            end
          end
        end
        W_SETUP: begin
          wren_q  <= EN_ON;
          state_q <= W_STROBE;
        end
        W_STROBE: begin
          // Release the strobe but keep data driven for one hold cycle.
          wren_q      <= EN_OFF;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= '0;
          state_q     <= W_HOLD;
        end
        W_HOLD: begin
          drive_q     <= 1'b0;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
        R_SETUP: begin
          oen_q   <= EN_ON;
          wait_q  <= '0;
          state_q <= R_WAIT;
        end
        R_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            rsp_rdata_q <= data_in;
            oen_q       <= EN_OFF;
            rsp_valid_q <= 1'b1;
            state_q     <= R_TURN;
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        R_TURN: begin
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign address       = addr_q;
  assign WrEn          = wren_q;
  assign OutEn         = oen_q;
  assign dbg_state_o   = state_q;
  assign dbg_data_oe_o = drive_q;

endmodule
